// File: rtl/sevseg_pkg.sv
// Shared constants and nibble-to-segment decode for the 8-digit seven-segment scanner.
// Segment patterns are active-low, ordered g,f,e,d,c,b,a.
package sevseg_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  // Non-BCD codes 10..15 render as a dash so corrupt data is visible.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_decode = SEG_0;
      4'd1:    seg_decode = SEG_1;
      4'd2:    seg_decode = SEG_2;
      4'd3:    seg_decode = SEG_3;
      4'd4:    seg_decode = SEG_4;
      4'd5:    seg_decode = SEG_5;
      4'd6:    seg_decode = SEG_6;
      4'd7:    seg_decode = SEG_7;
      4'd8:    seg_decode = SEG_8;
      4'd9:    seg_decode = SEG_9;
      default: seg_decode = SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/sevseg_scan8_decoder.sv
// Combinational BCD nibble to active-low seven-segment pattern.
import sevseg_pkg::*;

module sevseg_decoder (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = seg_decode(nibble);

endmodule

// File: rtl/sevseg_scan8.sv
// 8-digit multiplexed seven-segment scanner with per-frame snapshot and blanking guard.
// Optional leading-zero blanking per 4-digit group when SEVSEG_LZB_EN is defined.
import sevseg_pkg::*;

module sevseg_scan8 #(
  parameter int         TICKS_PER_DIGIT = 100000,
  parameter int         BLANK_TICKS     = 256,
  parameter logic [7:0] DP_MASK         = 8'h10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] digits,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int TW = $clog2(TICKS_PER_DIGIT);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_DIGIT - 1);
  localparam logic [TW-1:0] TICK_BLANK = TW'(BLANK_TICKS);

  logic [TW-1:0] tick;
  logic [2:0]    idx;
  logic [31:0]   snap;
  logic [3:0]    cur_nib;
  logic [6:0]    dec_seg;
  logic          lz_blank;
  logic          slot_end;
  logic          frame_end;

  assign slot_end  = (tick == TICK_LAST);
  assign frame_end = slot_end && (idx == 3'd7);
  assign cur_nib   = snap[{idx, 2'b00} +: 4];

  sevseg_decoder u_dec (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

`ifdef SEVSEG_LZB_EN
  // Blank when this digit and every higher digit of its group are zero;
  // the lowest digit of each group is always shown.
  always_comb begin
    lz_blank = (idx[1:0] != 2'd0);
    for (int j = 0; j < 4; j++) begin
      if ((2'(j) >= idx[1:0]) && (snap[{idx[2], 2'(j), 2'b00} +: 4] != 4'd0))
        lz_blank = 1'b0;
    end
  end
`else
  assign lz_blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      tick       <= '0;
      idx        <= 3'd0;
      snap       <= 32'd0;
      an         <= 8'hFF;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      tick <= slot_end ? '0 : tick + 1'b1;
      if (slot_end)
        idx <= idx + 3'd1;
      // Snapshot only at the frame boundary so a frame never tears.
      if (frame_end)
        snap <= digits;
      frame_done <= frame_end;
      if (tick < TICK_BLANK) begin
        an  <= 8'hFF;
        seg <= SEG_OFF;
        dp  <= 1'b1;
      end else begin
        an  <= ~(8'b1 << idx);
        seg <= lz_blank ? SEG_OFF : dec_seg;
        dp  <= ~DP_MASK[idx];
      end
    end
  end

endmodule

// File: tb/tb_sevseg_scan8.sv
// Directed bench for sevseg_scan8 with TICKS_PER_DIGIT=8, BLANK_TICKS=2.
module tb_sevseg_scan8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] digits = 32'd0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

`ifdef SEVSEG_LZB_EN
  localparam logic [6:0] ZLZ = 7'h7F;
`else
  localparam logic [6:0] ZLZ = 7'h40;
`endif

  typedef struct {
    logic [31:0] dig;
    int          f;
    int          d;
    int          t;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
  } vec_t;

  vec_t vecs[$];

  sevseg_scan8 #(
    .TICKS_PER_DIGIT (8),
    .BLANK_TICKS     (2),
    .DP_MASK         (8'h10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digits     (digits),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Output-cycle number (edges after release) at which frame f, digit d, tick t is visible.
  function automatic int kof(input int f, input int d, input int t);
    return f * 64 + d * 8 + t + 1;
  endfunction

  task automatic adv_to(input int k);
    while (cyc < k) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_an", 32'(an), 32'hFF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_fd", 32'(frame_done), 32'h0);
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    // Table of single-point observations: {digits, frame, digit, tick, an, seg, dp}
    vecs.push_back('{32'h0000_1234, 0, 4, 2, 8'hEF, 7'h40, 1'b0});
    vecs.push_back('{32'h0000_1234, 0, 0, 7, 8'hFE, 7'h40, 1'b1});
    vecs.push_back('{32'h0000_1234, 1, 0, 2, 8'hFE, 7'h19, 1'b1});
    vecs.push_back('{32'h0000_1234, 1, 1, 3, 8'hFD, 7'h30, 1'b1});
    vecs.push_back('{32'h0000_1234, 1, 2, 7, 8'hFB, 7'h24, 1'b1});
    vecs.push_back('{32'h0000_1234, 1, 3, 5, 8'hF7, 7'h79, 1'b1});
    vecs.push_back('{32'h0000_1234, 1, 3, 0, 8'hFF, 7'h7F, 1'b1});
    vecs.push_back('{32'h0000_1234, 1, 3, 1, 8'hFF, 7'h7F, 1'b1});
    vecs.push_back('{32'hB000_0000, 1, 7, 2, 8'h7F, 7'h3F, 1'b1});
    vecs.push_back('{32'h8765_0000, 1, 4, 3, 8'hEF, 7'h12, 1'b0});
    vecs.push_back('{32'h8765_0000, 1, 5, 3, 8'hDF, 7'h02, 1'b1});
    vecs.push_back('{32'h8765_0000, 1, 6, 4, 8'hBF, 7'h78, 1'b1});
    vecs.push_back('{32'h8765_0000, 1, 7, 6, 8'h7F, 7'h00, 1'b1});
    vecs.push_back('{32'h0000_00A9, 1, 0, 2, 8'hFE, 7'h10, 1'b1});
    vecs.push_back('{32'h0000_00A9, 1, 1, 2, 8'hFD, 7'h3F, 1'b1});
    vecs.push_back('{32'h0000_1020, 1, 0, 4, 8'hFE, 7'h40, 1'b1});
    vecs.push_back('{32'h0000_1020, 1, 1, 4, 8'hFD, 7'h24, 1'b1});
    vecs.push_back('{32'h0000_1020, 1, 2, 4, 8'hFB, 7'h40, 1'b1});
    vecs.push_back('{32'h0000_1020, 1, 3, 4, 8'hF7, 7'h79, 1'b1});
    vecs.push_back('{32'h0045_0007, 1, 0, 3, 8'hFE, 7'h78, 1'b1});
    vecs.push_back('{32'h0045_0007, 1, 1, 3, 8'hFD, ZLZ,   1'b1});
    vecs.push_back('{32'h0045_0007, 1, 2, 3, 8'hFB, ZLZ,   1'b1});
    vecs.push_back('{32'h0045_0007, 1, 3, 3, 8'hF7, ZLZ,   1'b1});
    vecs.push_back('{32'h0045_0007, 1, 4, 3, 8'hEF, 7'h12, 1'b0});
    vecs.push_back('{32'h0045_0007, 1, 5, 3, 8'hDF, 7'h19, 1'b1});
    vecs.push_back('{32'h0045_0007, 1, 6, 3, 8'hBF, ZLZ,   1'b1});
    vecs.push_back('{32'h0045_0007, 1, 7, 3, 8'h7F, ZLZ,   1'b1});

    // Reset, then a full frame plus one slot with digits=0: blanking, scan order, frame_done.
    do_reset();
    for (int k = 1; k <= 72; k++) begin
      int t;
      int d;
      logic [7:0] ea;
      adv_to(k);
      t  = (k - 1) % 8;
      d  = ((k - 1) / 8) % 8;
      ea = 8'hFF;
      if (t >= 2) ea[d] = 1'b0;
      chk($sformatf("scan_an_k%0d", k), 32'(an), 32'(ea));
      chk($sformatf("scan_seg_k%0d", k), 32'(seg), (t >= 2) ? 32'h40 : 32'h7F);
      chk($sformatf("scan_dp_k%0d", k), 32'(dp), (t >= 2 && d == 4) ? 32'h0 : 32'h1);
      chk($sformatf("scan_fd_k%0d", k), 32'(frame_done), (k == 64) ? 32'h1 : 32'h0);
    end

    // Table-driven vectors, each from a fresh reset.
    for (int i = 0; i < vecs.size(); i++) begin
      do_reset();
      digits = vecs[i].dig;
      adv_to(kof(vecs[i].f, vecs[i].d, vecs[i].t));
      chk($sformatf("v%0d_an", i), 32'(an), 32'(vecs[i].an));
      chk($sformatf("v%0d_seg", i), 32'(seg), 32'(vecs[i].seg));
      chk($sformatf("v%0d_dp", i), 32'(dp), 32'(vecs[i].dp));
    end

    // Digits change mid-frame: old snapshot stays until the next boundary.
    do_reset();
    digits = 32'h0000_1234;
    adv_to(kof(1, 1, 0));
    digits = 32'h9999_9999;
    adv_to(kof(1, 2, 3));
    chk("mid_seg_d2", 32'(seg), 32'h24);
    chk("mid_an_d2", 32'(an), 32'hFB);
    adv_to(128);
    chk("mid_fd", 32'(frame_done), 32'h1);
    chk("mid_seg_d7_old", 32'(seg), 32'h40);
    chk("mid_an_d7", 32'(an), 32'h7F);
    adv_to(kof(2, 0, 2));
    chk("new_seg_d0", 32'(seg), 32'h10);
    chk("new_an_d0", 32'(an), 32'hFE);
    adv_to(kof(2, 5, 4));
    chk("new_seg_d5", 32'(seg), 32'h10);

    // Single-cycle reset pulse mid-frame.
    adv_to(kof(2, 6, 4));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("pulse_an", 32'(an), 32'hFF);
    chk("pulse_seg", 32'(seg), 32'h7F);
    chk("pulse_dp", 32'(dp), 32'h1);
    chk("pulse_fd", 32'(frame_done), 32'h0);
    rst = 1'b0;
    cyc = 0;
    adv_to(2);
    chk("pulse_blank_an", 32'(an), 32'hFF);
    adv_to(3);
    chk("pulse_idx0_an", 32'(an), 32'hFE);
    chk("pulse_snap0_seg", 32'(seg), 32'h40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
